ifu_fetch: RTL and testbench



---
 rtl/ifu_fetch.sv | 150 +++++++++++++++
 tb/tb_ifu_fetch.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch
// Instruction fetch stage. Holds the PC and issues one AXI-lite read per
// instruction. It consumes the read beat and presents the fetched word to
// decode. It then waits for write-back to supply the next PC before it
// fetches again. Only one request is outstanding at any time.
//
// Ports
//   clk                         clock, rising edge
//   rst                         synchronous, active-low reset
//   araddr/arvalid/arready      AR channel toward DRAM (araddr = pc)
//   rdata/rresp/rvalid/rready   R channel from DRAM
//   inst/inst_pc/inst_err       latched instruction, its PC, error flag
//   inst_valid/inst_ready       handshake toward decode
//   npc/npc_valid/npc_ready     next PC from write-back
//   fetch_cnt                   completed R handshakes since reset
//
// Every handshake output is a pure decode of the state register, so no
// input reaches an output combinationally.
// ---------------------------------------------------------------------------
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      araddr,
    output logic             arvalid,
    input  logic             arready,
    input  logic [31:0]      rdata,
    input  logic [1:0]       rresp,
    input  logic             rvalid,
    output logic             rready,
    output logic [31:0]      inst,
    output logic [31:0]      inst_pc,
    output logic             inst_err,
    output logic             inst_valid,
    input  logic             inst_ready,
    input  logic [31:0]      npc,
    input  logic             npc_valid,
    output logic             npc_ready,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic [2:0] {
        S_BOOT = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_OUT  = 3'd3,
        S_PC   = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [31:0]      pc_r;
    logic [31:0]      inst_r;
    logic [31:0]      inst_pc_r;
    logic             inst_err_r;
    logic [CNT_W-1:0] fetch_cnt_r;

    // Any response other than OKAY marks the instruction as erroneous.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != 2'b00);
    endfunction

    // Output decode: all outputs come straight from registers.
    assign arvalid    = (state_r == S_AR);
    assign rready     = (state_r == S_R);
    assign inst_valid = (state_r == S_OUT);
    assign npc_ready  = (state_r == S_PC);
    assign araddr     = pc_r;
    assign inst       = inst_r;
    assign inst_pc    = inst_pc_r;
    assign inst_err   = inst_err_r;
    assign fetch_cnt  = fetch_cnt_r;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S_BOOT;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic. Each state waits indefinitely for its partner.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_BOOT: begin
                state_s = S_AR;
            end
            S_AR: begin
                if (arready) begin
                    state_s = S_R;
                end else begin
                    state_s = S_AR;
                end
            end
            S_R: begin
                if (rvalid) begin
                    state_s = S_OUT;
                end else begin
                    state_s = S_R;
                end
            end
            S_OUT: begin
                if (inst_ready) begin
                    state_s = S_PC;
                end else begin
                    state_s = S_OUT;
                end
            end
            S_PC: begin
                if (npc_valid) begin
                    state_s = S_AR;
                end else begin
                    state_s = S_PC;
                end
            end
            default: begin
                state_s = S_BOOT;
            end
        endcase
    end

    // Datapath: capture the R beat, count it, and load the next PC.
    // A beat that arrives during reset is dropped, because DRAM resets with us.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_r        <= RESET_PC;
            inst_r      <= 32'h0000_0000;
            inst_pc_r   <= 32'h0000_0000;
            inst_err_r  <= 1'b0;
            fetch_cnt_r <= '0;
        end else begin
            if ((state_r == S_R) && rvalid) begin
                inst_r      <= rdata;
                inst_pc_r   <= pc_r;
                inst_err_r  <= resp_is_err(rresp);
                fetch_cnt_r <= fetch_cnt_r + CNT_W'(1);
            end
            // npc is taken as-is; alignment is the producer's concern.
            if ((state_r == S_PC) && npc_valid) begin
                pc_r <= npc;
            end
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] npc;
    logic        npc_valid;
    logic        npc_ready;
    logic [31:0] fetch_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int ar_hs       = 0;
    int r_hs        = 0;
    int ar_snap;
    int r_snap;

    ifu_fetch #(.RESET_PC(32'h8000_0000), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_err   (inst_err),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .npc        (npc),
        .npc_valid  (npc_valid),
        .npc_ready  (npc_ready),
        .fetch_cnt  (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count handshakes in mid-cycle, when inputs and outputs are both settled.
    always @(negedge clk) begin
        if (rst && arvalid && arready) ar_hs = ar_hs + 1;
        if (rst && rready && rvalid) r_hs = r_hs + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_hs(input string tag, input logic [3:0] exp);
        chk(tag, {28'h0, arvalid, rready, inst_valid, npc_ready}, {28'h0, exp});
    endtask

    initial begin
        rst        = 1'b0;
        arready    = 1'b0;
        rdata      = 32'h0;
        rresp      = 2'b00;
        rvalid     = 1'b0;
        inst_ready = 1'b0;
        npc        = 32'h0;
        npc_valid  = 1'b0;

        // Reset held for three edges.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_hs("rst_hs", 4'b0000);
            chk("rst_cnt", fetch_cnt, 32'h0);
        end
        rst = 1'b1;
        chk_hs("rel1_hs", 4'b0000);
        chk("rel1_cnt", fetch_cnt, 32'h0);
        tick();
        chk_hs("rel2_hs", 4'b1000);
        chk("rel2_araddr", araddr, 32'h8000_0000);

        // Everyone always ready.
        arready    = 1'b1;
        rdata      = 32'h0000_0413;
        rresp      = 2'b00;
        rvalid     = 1'b1;
        inst_ready = 1'b1;
        npc        = 32'h8000_0004;
        npc_valid  = 1'b1;
        tick();
        chk_hs("rt_r_hs", 4'b0100);
        tick();
        chk_hs("rt_out_hs", 4'b0010);
        chk("rt_inst", inst, 32'h0000_0413);
        chk("rt_inst_pc", inst_pc, 32'h8000_0000);
        chk("rt_err", {31'h0, inst_err}, 32'h0);
        chk("rt_cnt", fetch_cnt, 32'h1);
        tick();
        chk_hs("rt_pc_hs", 4'b0001);
        tick();
        chk_hs("rt_ar_hs", 4'b1000);
        chk("rt_araddr", araddr, 32'h8000_0004);

        // AR stalled for 5 cycles, then R delayed by 3 cycles.
        ar_snap   = ar_hs;
        r_snap    = r_hs;
        arready   = 1'b0;
        rvalid    = 1'b0;
        npc_valid = 1'b0;
        rdata     = 32'h0010_0093;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_hs("arwait_hs", 4'b1000);
            chk("arwait_araddr", araddr, 32'h8000_0004);
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_hs("rwait_hs", 4'b0100);
            chk("rwait_cnt", fetch_cnt, 32'h1);
        end
        rvalid = 1'b1;
        tick();
        rvalid     = 1'b0;
        inst_ready = 1'b0;
        chk_hs("stall_out_hs", 4'b0010);
        chk("stall_inst", inst, 32'h0010_0093);
        chk("stall_inst_pc", inst_pc, 32'h8000_0004);
        chk("stall_cnt", fetch_cnt, 32'h2);
        chk("ar_hs_count", ar_hs - ar_snap, 32'd1);
        chk("r_hs_count", r_hs - r_snap, 32'd1);

        // Decode stalls for 10 cycles; a stray npc pulse must be ignored.
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                npc       = 32'h8000_1000;
                npc_valid = 1'b1;
            end else begin
                npc_valid = 1'b0;
            end
            tick();
            chk_hs("dstall_hs", 4'b0010);
            chk("dstall_inst", inst, 32'h0010_0093);
            chk("dstall_inst_pc", inst_pc, 32'h8000_0004);
            chk("dstall_pc", araddr, 32'h8000_0004);
        end
        npc_valid  = 1'b0;
        inst_ready = 1'b1;
        tick();
        chk_hs("dstall_pc_hs", 4'b0001);
        chk("dstall_pc_after", araddr, 32'h8000_0004);
        npc       = 32'h8000_0008;
        npc_valid = 1'b1;
        tick();
        npc_valid = 1'b0;
        chk("err_araddr", araddr, 32'h8000_0008);

        // Error response, then a clean fetch that clears the flag.
        arready = 1'b1;
        rvalid  = 1'b1;
        rresp   = 2'b10;
        rdata   = 32'hDEAD_BEEF;
        tick();
        tick();
        chk_hs("err_out_hs", 4'b0010);
        chk("err_inst", inst, 32'hDEAD_BEEF);
        chk("err_flag", {31'h0, inst_err}, 32'h1);
        chk("err_inst_pc", inst_pc, 32'h8000_0008);
        chk("err_cnt", fetch_cnt, 32'h3);
        npc       = 32'h8000_000C;
        npc_valid = 1'b1;
        tick();
        tick();
        npc_valid = 1'b0;
        rresp     = 2'b00;
        rdata     = 32'h0000_0013;
        chk("ok_araddr", araddr, 32'h8000_000C);
        tick();
        tick();
        chk("ok_inst", inst, 32'h0000_0013);
        chk("ok_flag", {31'h0, inst_err}, 32'h0);
        chk("ok_cnt", fetch_cnt, 32'h4);
        npc       = 32'h8000_0010;
        npc_valid = 1'b1;
        tick();
        tick();
        npc_valid = 1'b0;
        rvalid    = 1'b0;
        chk_hs("mid_ar_hs", 4'b1000);
        tick();
        chk_hs("mid_r_hs", 4'b0100);

        // Reset lands on the same edge as an R beat.
        rst     = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'h5555_5555;
        arready = 1'b0;
        tick();
        chk_hs("mrst_hs", 4'b0000);
        chk("mrst_inst", inst, 32'h0);
        chk("mrst_cnt", fetch_cnt, 32'h0);
        chk("mrst_araddr", araddr, 32'h8000_0000);
        rst    = 1'b1;
        rvalid = 1'b0;
        tick();
        chk_hs("mrst_ar_hs", 4'b1000);
        chk("mrst_ar_araddr", araddr, 32'h8000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
